tft_timing_gen: RTL

//  Parametrised RGB565 TFT timing generator with power-up/down sequencing and a pixel-fetch interface.

---
 rtl/tft_timing_gen.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tft_timing_gen.sv
// tft_timing_gen: RGB565 TFT raster timing generator with power-up/down sequencing and pixel fetch.
// Latency: pix_req/pix_x/pix_y are combinational from the raster counters; hsync/vsync/de/rgb for a
//   counter position appear PIX_LATENCY+1 cycles later. No backpressure: the pixel source must return
//   pix_rgb exactly PIX_LATENCY cycles after pix_req.
// Ports: clk_pix/rstn (async active-low) | enable, test_mode | pix_rgb in, pix_req/pix_x/pix_y out |
//   frame_start, disp_en, hsync, vsync, de, dclk, r/g/b to the panel.
// Optional feature macro: TFT_TEST_PATTERN_EN (test_mode selects an internal quadrant pattern).
module tft_timing_gen #(
    parameter int H_ACTIVE        = 800,
    parameter int H_FP            = 40,
    parameter int H_SYNC          = 128,
    parameter int H_BP            = 88,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit HS_POL          = 1'b0,
    parameter bit VS_POL          = 1'b0,
    parameter int PWR_WAIT_CYCLES = 500000,
    parameter int PIX_LATENCY     = 2,
    parameter bit DCLK_INV        = 1'b0,
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk_pix,
    input  logic          rstn,
    input  logic          enable,
    input  logic          test_mode,
    input  logic [15:0]   pix_rgb,
    output logic          pix_req,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          disp_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          dclk,
    output logic [4:0]    r,
    output logic [5:0]    g,
    output logic [4:0]    b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WW      = (PWR_WAIT_CYCLES > 1) ? $clog2(PWR_WAIT_CYCLES) : 1;
    // Stage of the sideband pipe that holds a position during the cycle its pixel is captured.
    localparam int CAP     = (PIX_LATENCY > 0) ? PIX_LATENCY - 1 : 0;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    // A zero wait is treated as a single cycle in PWR_WAIT.
    localparam logic [WW-1:0] WAIT_LAST = WW'((PWR_WAIT_CYCLES > 0) ? PWR_WAIT_CYCLES - 1 : 0);
    localparam logic [31:0]   H_ACT_END = H_ACTIVE;
    localparam logic [31:0]   V_ACT_END = V_ACTIVE;
    localparam logic [31:0]   HS_START  = H_ACTIVE + H_FP;
    localparam logic [31:0]   HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0]   VS_START  = V_ACTIVE + V_FP;
    localparam logic [31:0]   VS_END    = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;

    logic            counting;
    logic            h_last, v_last;
    logic [31:0]     hpos, vpos;
    logic            hs_raw, vs_raw, de_raw;

    assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign h_last   = (hcnt_q == H_LAST);
    assign v_last   = (vcnt_q == V_LAST);
    assign hpos     = 32'(hcnt_q);
    assign vpos     = 32'(vcnt_q);

    // ---------------------------------------------------------------- FSM + raster counters
    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        // Counters sit at (0,0) outside RUN/DRAIN so the first RUN cycle is position (0,0).
        hcnt_d  = '0;
        vcnt_d  = '0;
        if (counting) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
                vcnt_d = vcnt_q;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PWR_WAIT;
                    wait_d  = '0;
                end
            end
            ST_PWR_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Finish the current frame so the panel sees a complete last frame of syncs.
                if (h_last && v_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- pixel fetch
    assign pix_req     = (state_q == ST_RUN) && (hpos < H_ACT_END) && (vpos < V_ACT_END);
    assign pix_x       = pix_req ? hcnt_q[XW-1:0] : '0;
    assign pix_y       = pix_req ? vcnt_q[YW-1:0] : '0;
    assign frame_start = (state_q == ST_RUN) && (hcnt_q == '0) && (vcnt_q == '0);
    assign disp_en     = counting;

    // In DRAIN no pixel is requested, so de for drain positions is naturally 0.
    assign de_raw = pix_req;
    assign hs_raw = counting && (hpos >= HS_START) && (hpos < HS_END);
    assign vs_raw = counting && (vpos >= VS_START) && (vpos < VS_END);

    // ---------------------------------------------------------------- sideband delay line
    // Stage i holds the position from i+1 cycles ago; the last stage drives the pins.
    logic [PIX_LATENCY:0] hs_pipe_q, hs_pipe_d;
    logic [PIX_LATENCY:0] vs_pipe_q, vs_pipe_d;
    logic [PIX_LATENCY:0] de_pipe_q, de_pipe_d;

    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        de_pipe_d    = de_pipe_q;
        hs_pipe_d[0] = hs_raw;
        vs_pipe_d[0] = vs_raw;
        de_pipe_d[0] = de_raw;
        for (int i = 1; i <= PIX_LATENCY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
            de_pipe_d[i] = de_pipe_q[i-1];
        end
        if (!counting) begin
            hs_pipe_d = '0;
            vs_pipe_d = '0;
            de_pipe_d = '0;
        end
    end

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
        end else begin
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
        end
    end

    // ---------------------------------------------------------------- pixel capture
    logic        de_cap;
    logic [15:0] pix_in;
    logic [15:0] rgb_q, rgb_d;

    always_comb begin
        de_cap = de_raw;
        if (PIX_LATENCY > 0) de_cap = de_pipe_q[CAP];
    end

`ifdef TFT_TEST_PATTERN_EN
    localparam int          XD     = (PIX_LATENCY > 0) ? PIX_LATENCY : 1;
    localparam logic [31:0] H_HALF = H_ACTIVE / 2;
    localparam logic [31:0] V_HALF = V_ACTIVE / 2;

    // Column/row of the pixel being captured, delayed alongside the sidebands.
    logic [XW-1:0] x_pipe_q [XD];
    logic [YW-1:0] y_pipe_q [XD];
    logic [XW-1:0] x_cap;
    logic [YW-1:0] y_cap;

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < XD; i++) begin
                x_pipe_q[i] <= '0;
                y_pipe_q[i] <= '0;
            end
        end else begin
            x_pipe_q[0] <= pix_x;
            y_pipe_q[0] <= pix_y;
            for (int i = 1; i < XD; i++) begin
                x_pipe_q[i] <= x_pipe_q[i-1];
                y_pipe_q[i] <= y_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        x_cap = pix_x;
        y_cap = pix_y;
        if (PIX_LATENCY > 0) begin
            x_cap = x_pipe_q[XD-1];
            y_cap = y_pipe_q[XD-1];
        end
    end

    always_comb begin
        pix_in = pix_rgb;
        if (test_mode) begin
            if (32'(x_cap) < H_HALF) begin
                pix_in = (32'(y_cap) < V_HALF) ? 16'hF800 : 16'h07E0;
            end else if (32'(y_cap) < V_HALF) begin
                pix_in = 16'h001F;
            end else begin
                pix_in = y_cap[0] ? 16'hFFFF : 16'h0000;
            end
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix_in           = pix_rgb;
`endif

    always_comb begin
        // Anything on pix_rgb outside a requested slot is ignored, keeping rgb at 0 when de is 0.
        rgb_d = de_cap ? pix_in : 16'h0000;
        if (!counting) rgb_d = 16'h0000;
    end

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) rgb_q <= '0;
        else       rgb_q <= rgb_d;
    end

    // ---------------------------------------------------------------- panel pins
    assign hsync = hs_pipe_q[PIX_LATENCY] ? HS_POL : ~HS_POL;
    assign vsync = vs_pipe_q[PIX_LATENCY] ? VS_POL : ~VS_POL;
    assign de    = de_pipe_q[PIX_LATENCY];
    assign r     = rgb_q[15:11];
    assign g     = rgb_q[10:5];
    assign b     = rgb_q[4:0];
    assign dclk  = DCLK_INV ? ~clk_pix : clk_pix;

endmodule
